// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a single-port RAM: one access per cycle, reads take priority
// over writes, read data returned with a one-cycle registered valid strobe.
module ram_fifo_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ram_cs_n,
  output logic             ram_we_n,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_acc, wr_acc;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign rd_valid = rd_pend_q;
  assign rd_data  = ram_dout;

  // Arbitration, RAM drive and next-state; accepts are suppressed while in reset.
  always_comb begin
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    wr_ready  = 1'b0;
    ram_cs_n  = 1'b1;
    ram_we_n  = 1'b1;
    ram_addr  = '0;
    ram_din   = '0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_pend_d = 1'b0;

    if (!reset) begin
      rd_acc   = rd_req && !empty;
      wr_ready = !full && !rd_acc;
      wr_acc   = wr_valid && wr_ready;
    end

    if (rd_acc) begin
      ram_cs_n  = 1'b0;
      ram_addr  = rd_ptr_q;
      rd_ptr_d  = rd_ptr_q + AW'(1);
      count_d   = count_q - CW'(1);
      rd_pend_d = 1'b1;
    end else if (wr_acc) begin
      ram_cs_n = 1'b0;
      ram_we_n = 1'b0;
      ram_addr = wr_ptr_q;
      ram_din  = wr_data;
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based FIFO model.
module tb_ram_fifo_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic             clk, reset;
  logic             wr_valid, wr_ready, rd_req, rd_valid;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic             full, empty;
  logic [AW:0]      count;
  logic             ram_cs_n, ram_we_n;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_din, ram_dout;

  int total = 0;
  int bad   = 0;

  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .full(full), .empty(empty), .count(count),
    .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM with registered read data; contents survive reset.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!ram_cs_n) begin
      if (!ram_we_n) mem[ram_addr] <= ram_din;
      else           ram_dout      <= mem[ram_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: contents queue plus push/pop totals for the expected addresses.
  logic [WIDTH-1:0] q[$];
  int               n_push = 0;
  int               n_pop  = 0;
  logic             m_pend = 1'b0;
  logic [WIDTH-1:0] m_pend_data = '0;

  always @(negedge clk) begin
    logic m_rd, m_wr, m_rdy;
    if (reset) begin
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_cs_n", 32'(ram_cs_n), 32'd1);
      chk("rst_we_n", 32'(ram_we_n), 32'd1);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_din", 32'(ram_din), 32'd0);
      q.delete();
      n_push = 0;
      n_pop  = 0;
      m_pend = 1'b0;
    end else begin
      m_rd  = rd_req && (q.size() != 0);
      m_rdy = (q.size() < DEPTH) && !m_rd;
      m_wr  = wr_valid && m_rdy;
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(m_pend));
      if (m_pend) chk("rd_data", 32'(rd_data), 32'(m_pend_data));
      chk("wr_ready", 32'(wr_ready), 32'(m_rdy));
      chk("cs_n", 32'(ram_cs_n), 32'(!(m_rd || m_wr)));
      chk("we_n", 32'(ram_we_n), 32'(!m_wr));
      chk("addr", 32'(ram_addr), m_rd ? 32'(n_pop % DEPTH) : m_wr ? 32'(n_push % DEPTH) : 32'd0);
      chk("din", 32'(ram_din), m_wr ? 32'(wr_data) : 32'd0);
      m_pend = m_rd;
      if (m_rd) begin
        m_pend_data = q.pop_front();
        n_pop++;
      end
      if (m_wr) begin
        q.push_back(wr_data);
        n_push++;
      end
    end
  end

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic step(input logic rst, input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
    @(posedge clk);
    #1;
    reset    = rst;
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b1;
    rd_req   = 1'b1;
    wr_data  = 8'd77;

    repeat (2) begin
      step(1'b1, 1'b1, 8'd77, 1'b1);
      chk("lit_rst_cs_n", 32'(ram_cs_n), 32'd1);
      chk("lit_rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("lit_rst_count", 32'(count), 32'd0);
      chk("lit_rst_empty", 32'(empty), 32'd1);
      chk("lit_rst_rd_valid", 32'(rd_valid), 32'd0);
    end

    // Write burst 5, 12, 36.
    step(1'b0, 1'b1, 8'd5, 1'b0);
    chk("lit_wr0_we_n", 32'(ram_we_n), 32'd0);
    chk("lit_wr0_addr", 32'(ram_addr), 32'd0);
    chk("lit_wr0_din", 32'(ram_din), 32'd5);
    step(1'b0, 1'b1, 8'd12, 1'b0);
    chk("lit_wr1_addr", 32'(ram_addr), 32'd1);
    chk("lit_wr1_din", 32'(ram_din), 32'd12);
    step(1'b0, 1'b1, 8'd36, 1'b0);
    chk("lit_wr2_addr", 32'(ram_addr), 32'd2);
    chk("lit_wr2_din", 32'(ram_din), 32'd36);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("lit_burst_count", 32'(count), 32'd3);

    // Read burst.
    step(1'b0, 1'b0, 8'd0, 1'b1);
    chk("lit_rd0_we_n", 32'(ram_we_n), 32'd1);
    chk("lit_rd0_addr", 32'(ram_addr), 32'd0);
    chk("lit_rd0_valid", 32'(rd_valid), 32'd0);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    chk("lit_rd1_addr", 32'(ram_addr), 32'd1);
    chk("lit_rd1_valid", 32'(rd_valid), 32'd1);
    chk("lit_rd1_data", 32'(rd_data), 32'd5);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    chk("lit_rd2_addr", 32'(ram_addr), 32'd2);
    chk("lit_rd2_data", 32'(rd_data), 32'd12);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("lit_rd3_valid", 32'(rd_valid), 32'd1);
    chk("lit_rd3_data", 32'(rd_data), 32'd36);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("lit_rd4_valid", 32'(rd_valid), 32'd0);
    chk("lit_rd4_empty", 32'(empty), 32'd1);

    // Fill, hold off the 9th write, read one, then wrap the held write to address 0.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(10 + i), 1'b0);
    step(1'b0, 1'b1, 8'd99, 1'b0);
    chk("lit_full", 32'(full), 32'd1);
    chk("lit_full_wr_ready", 32'(wr_ready), 32'd0);
    step(1'b0, 1'b1, 8'd99, 1'b1);
    chk("lit_full_rd_addr", 32'(ram_addr), 32'd0);
    chk("lit_full_rd_we_n", 32'(ram_we_n), 32'd1);
    step(1'b0, 1'b1, 8'd99, 1'b0);
    chk("lit_wrap_wr_ready", 32'(wr_ready), 32'd1);
    chk("lit_wrap_addr", 32'(ram_addr), 32'd0);
    chk("lit_wrap_we_n", 32'(ram_we_n), 32'd0);
    chk("lit_wrap_rd_data", 32'(rd_data), 32'd10);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("lit_wrap_count", 32'(count), 32'd8);

    // Contention at count 2.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 8'd7, 1'b0);
    step(1'b0, 1'b1, 8'd8, 1'b0);
    step(1'b0, 1'b1, 8'd9, 1'b1);
    chk("lit_cont_we_n", 32'(ram_we_n), 32'd1);
    chk("lit_cont_cs_n", 32'(ram_cs_n), 32'd0);
    chk("lit_cont_wr_ready", 32'(wr_ready), 32'd0);
    step(1'b0, 1'b1, 8'd9, 1'b0);
    chk("lit_cont_count1", 32'(count), 32'd1);
    chk("lit_cont_wr_acc", 32'(wr_ready), 32'd1);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("lit_cont_count2", 32'(count), 32'd2);

    // Read request while empty is ignored.
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    chk("lit_empty_cs_n", 32'(ram_cs_n), 32'd1);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("lit_empty_rd_valid", 32'(rd_valid), 32'd0);

    // Reset right after a read accept kills the pending valid at once.
    step(1'b0, 1'b1, 8'd55, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    chk("lit_pend_before_rst", 32'(rd_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("lit_pend_after_rst", 32'(rd_valid), 32'd0);
    chk("lit_count_after_rst", 32'(count), 32'd0);
    @(negedge clk);

    // Randomized traffic with shifting read bias and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      int unsigned bias;
      bias = ((i / 200) % 2 == 0) ? 30 : 70;
      step(($urandom_range(99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 60) ? 1'b1 : 1'b0,
           8'($urandom),
           ($urandom_range(99) < bias) ? 1'b1 : 1'b0);
    end

    step(1'b0, 1'b0, 8'd0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
